// File: rtl/mesi_isc_snoop_sched.sv
// Snoop scheduler for the MESI coherence controller.
// Takes broadcast requests from the broadcast FIFO one at a time. For each
// request it sends snoops to the three non-initiator CPUs, waits for their
// acks, then grants the initiator and waits for its ack. A watchdog limits
// how long each wait phase can last.
module mesi_isc_snoop_sched #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int TIMEOUT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          broad_fifo_status_empty_i,
  input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
  input  logic [1:0]                    broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
  input  logic [3:0]                    cbus_ack_array_i,
  output logic                          broad_fifo_rd_o,
  output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
  output logic [BROAD_ID_WIDTH-1:0]     cbus_id_o,
  output logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SNOOP = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

  // The counter saturates at WDOG_LIMIT. It expires on the edge where it
  // would reach that value.
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LIMIT = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST  = WDOG_LIMIT - TIMEOUT_WIDTH'(1);

  logic [1:0]                  state_reg, state_next;
  logic [3:0]                  pending_reg, pending_next;
  logic [TIMEOUT_WIDTH-1:0]    wdog_reg, wdog_next;
  logic                        timeout_reg, timeout_next;
  logic [BROAD_TYPE_WIDTH-1:0] type_reg;
  logic [1:0]                  cpu_reg;
  logic [ADDR_WIDTH-1:0]       addr_reg;
  logic [BROAD_ID_WIDTH-1:0]   id_reg;

  logic       pop;
  logic       is_req;
  logic [3:0] pending_left;
  logic       init_ack;
  logic       wdog_expire;

  // Hold the pop low while reset is asserted, so every output is quiet during reset.
  assign pop          = (state_reg == IDLE) && !broad_fifo_status_empty_i && !rst;
  assign is_req       = (broad_type_i == TYPE_WR) || (broad_type_i == TYPE_RD);
  assign pending_left = pending_reg & ~cbus_ack_array_i;
  assign init_ack     = cbus_ack_array_i[cpu_reg];
  assign wdog_expire  = (wdog_reg == WDOG_LAST);

  // Next-state logic: pop/dispatch, collect snoop acks, grant the initiator, watchdog escape
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop && is_req) begin
          state_next   = SNOOP;
          pending_next = 4'b1111 & ~(4'b0001 << broad_cpu_id_i);
        end
      end
      SNOOP: begin
        pending_next = pending_left;
        if (pending_left == 4'b0000) begin
          state_next = GRANT;
        end else if (wdog_expire) begin
          pending_next = 4'b0000;
          state_next   = GRANT;
          timeout_next = 1'b1;
        end
      end
      GRANT: begin
        if (init_ack) begin
          state_next = IDLE;
        end else if (wdog_expire) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = 4'b0000;
      end
    endcase
  end

  // Watchdog: restarts on every state change and counts only while busy. It never wraps.
  always_comb begin
    wdog_next = wdog_reg;
    if (state_next != state_reg) begin
      wdog_next = '0;
    end else if ((state_reg != IDLE) && (wdog_reg != WDOG_LIMIT)) begin
      wdog_next = wdog_reg + TIMEOUT_WIDTH'(1);
    end
  end

  // State and request registers. The head entry is latched on every pop, including NOP entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= 4'b0000;
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
      type_reg    <= '0;
      cpu_reg     <= 2'd0;
      addr_reg    <= '0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      wdog_reg    <= wdog_next;
      timeout_reg <= timeout_next;
      if (pop) begin
        type_reg <= broad_type_i;
        cpu_reg  <= broad_cpu_id_i;
        addr_reg <= broad_addr_i;
        id_reg   <= broad_id_i;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmd
      logic [CBUS_CMD_WIDTH-1:0] cmd_slice;
      // Per-CPU command: a snoop while this CPU is pending, or an enable if this CPU is the granted initiator
      always_comb begin
        cmd_slice = CMD_NOP;
        if ((state_reg == SNOOP) && pending_reg[gi]) begin
          cmd_slice = (type_reg == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
        end else if ((state_reg == GRANT) && (cpu_reg == 2'(gi))) begin
          cmd_slice = (type_reg == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
        end
      end
      assign cbus_cmd_array_o[gi*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = cmd_slice;
    end
  endgenerate

  assign broad_fifo_rd_o = pop;
  assign busy_o          = (state_reg != IDLE);
  assign timeout_o       = timeout_reg;
  assign cbus_addr_o     = addr_reg;
  assign cbus_id_o       = id_reg;

endmodule

// File: tb/tb_mesi_isc_snoop_sched.sv
// Scoreboard testbench for mesi_isc_snoop_sched.
// The stimulus code pushes expected output events, each tagged with a cycle
// number. A negedge monitor pops an entry whenever the DUT shows an
// observable event and compares it with the popped entry.
module tb_mesi_isc_snoop_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty;
  logic [31:0] baddr;
  logic [1:0]  btype;
  logic [1:0]  bcpu;
  logic [6:0]  bid;
  logic [3:0]  ack;
  logic        rd;
  logic [31:0] caddr;
  logic [6:0]  cid;
  logic [11:0] cmd;
  logic        busy;
  logic        tmo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mesi_isc_snoop_sched #(
    .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .BROAD_TYPE_WIDTH(2),
    .BROAD_ID_WIDTH(7), .TIMEOUT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .broad_fifo_status_empty_i(empty), .broad_addr_i(baddr),
    .broad_type_i(btype), .broad_cpu_id_i(bcpu), .broad_id_i(bid),
    .cbus_ack_array_i(ack), .broad_fifo_rd_o(rd),
    .cbus_addr_o(caddr), .cbus_id_o(cid), .cbus_cmd_array_o(cmd),
    .busy_o(busy), .timeout_o(tmo)
  );

  typedef struct {
    logic [1:0]  t;
    logic [1:0]  cpu;
    logic [31:0] addr;
    logic [6:0]  id;
  } ent_t;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        tmo;
    logic        busy;
    logic [11:0] cmd;
    logic        chk;
    logic [31:0] addr;
    logic [6:0]  id;
  } exp_t;

  ent_t fifo[$];
  exp_t exp_q[$];

  function automatic logic [11:0] cm(input int s3, input int s2, input int s1, input int s0);
    return {s3[2:0], s2[2:0], s1[2:0], s0[2:0]};
  endfunction

  task automatic expect_ev(input int dc, input logic erd, input logic etmo, input logic ebusy,
                           input logic [11:0] ecmd, input logic echk,
                           input logic [31:0] eaddr, input logic [6:0] eid);
    exp_t e;
    e.cyc = cyc + dc; e.rd = erd; e.tmo = etmo; e.busy = ebusy;
    e.cmd = ecmd; e.chk = echk; e.addr = eaddr; e.id = eid;
    exp_q.push_back(e);
  endtask

  task automatic refresh();
    if (fifo.size() > 0) begin
      empty = 1'b0; btype = fifo[0].t; bcpu = fifo[0].cpu;
      baddr = fifo[0].addr; bid = fifo[0].id;
    end else begin
      empty = 1'b1; btype = 2'd0; bcpu = 2'd0; baddr = 32'd0; bid = 7'd0;
    end
  endtask

  task automatic push_ent(input logic [1:0] t, input logic [1:0] c,
                          input logic [31:0] a, input logic [6:0] i);
    ent_t e;
    e.t = t; e.cpu = c; e.addr = a; e.id = i;
    fifo.push_back(e);
    refresh();
  endtask

  // Advance one cycle. The FIFO model pops on the edge after it sees rd high.
  task automatic step();
    logic rd_seen;
    @(negedge clk);
    rd_seen = rd;
    @(posedge clk);
    #1;
    if (rd_seen && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic cyc_ack(input logic [3:0] a);
    ack = a;
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end else begin
      $display("check %s ok value=%0h", name, act);
    end
  endtask

  // Monitor: one comparison per observable output event
  logic [11:0] prev_cmd  = 12'd0;
  logic        prev_busy = 1'b0;
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = rd || tmo || (cmd != prev_cmd) || (busy != prev_busy);
    prev_cmd  = cmd;
    prev_busy = busy;
    if (ev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d rd=%0b tmo=%0b busy=%0b cmd=%03h expected=no_event",
                 cyc, rd, tmo, busy, cmd);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.rd !== rd || e.tmo !== tmo || e.busy !== busy || e.cmd !== cmd ||
            (e.chk && (caddr !== e.addr || cid !== e.id))) begin
          failures++;
          $display("FAIL event got cyc=%0d rd=%0b tmo=%0b busy=%0b cmd=%03h addr=%08h id=%02h expected cyc=%0d rd=%0b tmo=%0b busy=%0b cmd=%03h addr=%08h id=%02h chk_ai=%0b",
                   cyc, rd, tmo, busy, cmd, caddr, cid,
                   e.cyc, e.rd, e.tmo, e.busy, e.cmd, e.addr, e.id, e.chk);
        end else begin
          $display("event ok cyc=%0d rd=%0b tmo=%0b busy=%0b cmd=%03h addr=%08h id=%02h",
                   cyc, rd, tmo, busy, cmd, caddr, cid);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ack = 4'd0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd", {31'd0, rd}, 32'd0);
    chk("reset_cmd", {20'd0, cmd}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_timeout", {31'd0, tmo}, 32'd0);
    chk("reset_addr", caddr, 32'd0);
    chk("reset_id", {25'd0, cid}, 32'd0);
    rst = 1'b0;
    step();

    // Scenario 1: WR from CPU2 with staggered snoop acks
    push_ent(2'd1, 2'd2, 32'h1000, 7'd5);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h0, 7'd0);
    expect_ev(1, 0, 0, 1, cm(1,0,1,1), 1, 32'h1000, 7'd5);
    expect_ev(3, 0, 0, 1, cm(1,0,1,0), 0, 32'h0, 7'd0);
    expect_ev(4, 0, 0, 1, cm(0,0,1,0), 0, 32'h0, 7'd0);
    expect_ev(5, 0, 0, 1, cm(0,3,0,0), 0, 32'h0, 7'd0);
    expect_ev(7, 0, 0, 0, 12'd0, 1, 32'h1000, 7'd5);
    cyc_ack(4'b0000); cyc_ack(4'b0000); cyc_ack(4'b0001); cyc_ack(4'b1000);
    cyc_ack(4'b0010); cyc_ack(4'b0000); cyc_ack(4'b0100); cyc_ack(4'b0000);
    cyc_ack(4'b0000);

    // Scenario 2: RD from CPU0, a spurious ack on CPU0, then all three acks in one cycle
    push_ent(2'd2, 2'd0, 32'h0abc, 7'd9);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h1000, 7'd5);
    expect_ev(1, 0, 0, 1, cm(2,2,2,0), 1, 32'h0abc, 7'd9);
    expect_ev(3, 0, 0, 1, cm(0,0,0,4), 0, 32'h0, 7'd0);
    expect_ev(4, 0, 0, 0, 12'd0, 0, 32'h0, 7'd0);
    cyc_ack(4'b0000); cyc_ack(4'b0001); cyc_ack(4'b1110); cyc_ack(4'b0001);
    cyc_ack(4'b0000);

    // Scenario 3: empty FIFO for 10 cycles, then two queued requests back to back
    repeat (10) cyc_ack(4'b0000);
    push_ent(2'd1, 2'd1, 32'h2000, 7'h11);
    push_ent(2'd2, 2'd3, 32'h3000, 7'h22);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h0abc, 7'd9);
    expect_ev(1, 0, 0, 1, cm(1,1,0,1), 1, 32'h2000, 7'h11);
    expect_ev(2, 0, 0, 1, cm(0,0,3,0), 0, 32'h0, 7'd0);
    expect_ev(3, 1, 0, 0, 12'd0, 1, 32'h2000, 7'h11);
    expect_ev(4, 0, 0, 1, cm(0,2,2,2), 1, 32'h3000, 7'h22);
    expect_ev(5, 0, 0, 1, cm(4,0,0,0), 0, 32'h0, 7'd0);
    expect_ev(6, 0, 0, 0, 12'd0, 0, 32'h0, 7'd0);
    cyc_ack(4'b0000); cyc_ack(4'b1101); cyc_ack(4'b0010); cyc_ack(4'b0000);
    cyc_ack(4'b0111); cyc_ack(4'b1000); cyc_ack(4'b0000); cyc_ack(4'b0000);

    // Scenario 4: NOP entry is popped and dropped
    push_ent(2'd0, 2'd1, 32'h4000, 7'h33);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h3000, 7'h22);
    cyc_ack(4'b0000); cyc_ack(4'b0000); cyc_ack(4'b0000);

    // Scenario 5: CPU1 never acks the snoop and the initiator never acks the grant
    push_ent(2'd1, 2'd0, 32'h5000, 7'h44);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h4000, 7'h33);
    expect_ev(1, 0, 0, 1, cm(1,1,1,0), 1, 32'h5000, 7'h44);
    expect_ev(2, 0, 0, 1, cm(0,0,1,0), 0, 32'h0, 7'd0);
    expect_ev(8, 0, 1, 1, cm(0,0,0,3), 0, 32'h0, 7'd0);
    expect_ev(15, 0, 1, 0, 12'd0, 0, 32'h0, 7'd0);
    cyc_ack(4'b0000); cyc_ack(4'b1100);
    repeat (16) cyc_ack(4'b0000);

    // Scenario 6: reset in the middle of SNOOP, then the next entry is popped
    push_ent(2'd2, 2'd2, 32'h6000, 7'h55);
    push_ent(2'd1, 2'd3, 32'h7000, 7'h66);
    expect_ev(0, 1, 0, 0, 12'd0, 1, 32'h5000, 7'h44);
    expect_ev(1, 0, 0, 1, cm(2,0,2,2), 1, 32'h6000, 7'h55);
    expect_ev(2, 0, 0, 0, 12'd0, 1, 32'h0, 7'd0);
    expect_ev(4, 1, 0, 0, 12'd0, 1, 32'h0, 7'd0);
    expect_ev(5, 0, 0, 1, cm(0,1,1,1), 1, 32'h7000, 7'h66);
    expect_ev(6, 0, 0, 1, cm(3,0,0,0), 0, 32'h0, 7'd0);
    expect_ev(7, 0, 0, 0, 12'd0, 0, 32'h0, 7'd0);
    cyc_ack(4'b0000); cyc_ack(4'b0000);
    rst = 1'b1;
    #1;
    chk("async_rst_cmd", {20'd0, cmd}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_rd", {31'd0, rd}, 32'd0);
    chk("async_rst_addr", caddr, 32'd0);
    cyc_ack(4'b0000); cyc_ack(4'b0000);
    rst = 1'b0;
    cyc_ack(4'b0000); cyc_ack(4'b0111); cyc_ack(4'b1000); cyc_ack(4'b0000);
    repeat (3) cyc_ack(4'b0000);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesi_isc_snoop_sched.md
Name: mesi_isc_snoop_sched

Overview:
- Consumes one broadcast request at a time from the broadcast FIFO, i.e. the entries the breq FIFO stage writes.
- Issues the matching snoop command on the coherence bus to the three non-initiator CPUs and waits until each has acknowledged.
- Then grants the initiator CPU its write/read enable and waits for that acknowledge before popping the next request.
- A watchdog bounds each wait phase.

Parameters:
- CBUS_CMD_WIDTH, 3, width of each per-CPU coherence-bus command.
- ADDR_WIDTH, 32, broadcast address width.
- BROAD_TYPE_WIDTH, 2, broadcast type width.
- BROAD_ID_WIDTH, 7, broadcast request ID width.
- TIMEOUT_WIDTH, 8, watchdog counter width; limit = 2^TIMEOUT_WIDTH-1 cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  system reset, asynchronous, active-high
- broad_fifo_status_empty_i  input  1  broadcast FIFO empty
- broad_addr_i  input  ADDR_WIDTH  head-entry address
- broad_type_i  input  BROAD_TYPE_WIDTH  head-entry type (0 NOP, 1 WR, 2 RD, 3 reserved)
- broad_cpu_id_i  input  2  head-entry initiator CPU
- broad_id_i  input  BROAD_ID_WIDTH  head-entry request ID
- cbus_ack_array_i  input  4  per-CPU acknowledge, bit n = CPU n
- broad_fifo_rd_o  output  1  pop broadcast FIFO (one-cycle pulse)
- cbus_addr_o  output  ADDR_WIDTH  latched address of the active request
- cbus_id_o  output  BROAD_ID_WIDTH  latched ID of the active request
- cbus_cmd_array_o  output  4*CBUS_CMD_WIDTH  per-CPU command, slice n = CPU n
- busy_o  output  1  a request is active
- timeout_o  output  1  one-cycle pulse when the watchdog expires

Behaviour:
- Command encoding: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- Reset (async, rst=1):
  - state=IDLE; all outputs 0; pending mask=0; watchdog=0.
  - An in-flight request is dropped and is not re-read.
- States: IDLE, SNOOP, GRANT.
- IDLE:
  - If broad_fifo_status_empty_i=0, assert broad_fifo_rd_o this cycle.
  - At the same edge, latch addr/type/cpu_id/id from the head entry.
  - Next state is SNOOP if type is WR or RD; otherwise stay in IDLE (NOP/reserved entries are discarded, 1 pop per cycle max).
  - If empty, no pop.
- SNOOP entry:
  - pending mask = 4'b1111 with the initiator bit cleared.
  - cbus_cmd slice = WR_SNOOP (WR) or RD_SNOOP (RD) for each pending CPU; initiator slice = NOP.
  - First snoop command is visible the cycle after the pop (latency 1).
- SNOOP:
  - An ack on CPU n is honoured only while n is pending. It clears pending[n] at the clock edge; slice n becomes NOP the next cycle.
  - Acks on non-pending CPUs are ignored.
  - Several acks in one cycle are all honoured.
  - When pending becomes 0 (including all acks on the same cycle), next state is GRANT.
  - Broadcast FIFO is not read while busy.
- GRANT:
  - Initiator slice = EN_WR (WR) or EN_RD (RD); all other slices = NOP.
  - On initiator ack: next state IDLE, initiator slice becomes NOP.
  - A new pop may occur in the first IDLE cycle, so back-to-back requests cost one IDLE cycle each.
- busy_o = 1 in SNOOP and GRANT.
- cbus_addr_o/cbus_id_o hold the latched values until the next pop. They are 0 after reset.
- Watchdog:
  - Clears on every state change; increments each cycle in SNOOP or GRANT.
  - On reaching 2^TIMEOUT_WIDTH-1: pulse timeout_o for 1 cycle.
  - From SNOOP: force pending=0 and go to GRANT.
  - From GRANT: go to IDLE.
  - Counter does not wrap.
- An ack arriving on the same cycle the watchdog expires counts as the ack: no timeout pulse, normal transition.

Test Plan:
- Head {type=WR, cpu=2, addr=0x1000, id=5}, acks CPU0@+2, CPU1@+4, CPU3@+3 -> rd pulse 1 cycle; slices 0,1,3=1 and slice2=0 from the next cycle; each slice goes to 0 the cycle after its ack; slice2=3 after the last ack; initiator ack -> IDLE; cbus_addr_o=0x1000, cbus_id_o=5.
- Head RD from cpu=0 with all three acks on the same cycle -> GRANT next cycle, slice0=4; spurious ack on CPU0 during SNOOP is ignored.
- FIFO empty for 10 cycles -> broad_fifo_rd_o=0, cbus_cmd_array_o=0, busy_o=0; then two queued requests -> exactly one pop per request, second pop in the first IDLE cycle after the first GRANT ack.
- Head type=0 -> popped, busy_o stays 0, no commands issued.
- TIMEOUT_WIDTH=3, CPU1 never acks -> timeout_o pulse after 7 SNOOP cycles, then GRANT; withhold the GRANT ack -> second pulse after 7 cycles, then IDLE.
- Assert rst mid-SNOOP -> all outputs 0 asynchronously; after release, state is IDLE and the next pop reads the following FIFO entry.
